// File: rtl/bitmanip_unit_pkg.sv
// Shared types and helpers for the bit-manipulation execute unit.
// Counting helpers work on a 64-bit word and take the live operand width as an argument.
package bitmanip_unit_pkg;

  localparam int MaxXlen = 64;

  typedef logic [MaxXlen-1:0] word_t;

  typedef enum logic [4:0] {
    OpAndn   = 5'd0,
    OpOrn    = 5'd1,
    OpXnor   = 5'd2,
    OpClz    = 5'd3,
    OpCtz    = 5'd4,
    OpCpop   = 5'd5,
    OpMax    = 5'd6,
    OpMaxu   = 5'd7,
    OpMin    = 5'd8,
    OpMinu   = 5'd9,
    OpSextb  = 5'd10,
    OpSexth  = 5'd11,
    OpZexth  = 5'd12,
    OpRol    = 5'd13,
    OpRor    = 5'd14,
    OpOrcb   = 5'd15,
    OpRev8   = 5'd16,
    OpBset   = 5'd17,
    OpBclr   = 5'd18,
    OpBinv   = 5'd19,
    OpBext   = 5'd20,
    OpSh1add = 5'd21,
    OpSh2add = 5'd22,
    OpSh3add = 5'd23,
    OpClmul  = 5'd24,
    OpClmulh = 5'd25,
    OpClmulr = 5'd26
  } bit_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } bit_state_t;

  typedef struct packed {
    bit_op_t op;
    word_t   rs1;
    word_t   rs2;
  } bit_req_t;

  typedef struct packed {
    logic  valid;
    word_t result;
  } bit_rsp_t;

  function automatic logic is_clmul_op(bit_op_t op);
    return (op == OpClmul) || (op == OpClmulh) || (op == OpClmulr);
  endfunction

  // Highest set bit below xlen wins, so the last hit in an upward scan gives the count.
  function automatic int bit_clz(word_t x, int xlen);
    int n;
    n = xlen;
    for (int i = 0; i < MaxXlen; i++) begin
      if (i < xlen && x[i]) n = xlen - 1 - i;
    end
    return n;
  endfunction

  function automatic int bit_ctz(word_t x, int xlen);
    int n;
    n = xlen;
    for (int i = MaxXlen - 1; i >= 0; i--) begin
      if (i < xlen && x[i]) n = i;
    end
    return n;
  endfunction

  function automatic int bit_cpop(word_t x, int xlen);
    int n;
    n = 0;
    for (int i = 0; i < MaxXlen; i++) begin
      if (i < xlen && x[i]) n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/bit_clmul.sv
// Iterative carry-less multiplier: consumes STEP bits of b per cycle into a 2*XLEN accumulator.
// done is high in the final step cycle; product carries the finished value in that cycle.
module bit_clmul #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              kill,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              done,
  output logic [2*XLEN-1:0] product
);

  localparam int unsigned N    = XLEN / STEP;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  logic [2*XLEN-1:0] a_q, a_d, acc_q, acc_d, step_acc;
  logic [XLEN-1:0]   b_q, b_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              last;

  assign last    = (cnt_q == CntW'(N - 1));
  assign done    = busy_q && last;
  assign product = step_acc;

  always_comb begin
    step_acc = acc_q;
    for (int j = 0; j < STEP; j++) begin
      if (b_q[j]) step_acc = step_acc ^ (a_q << j);
    end
  end

  // a is pre-shifted and b pre-consumed so each step only looks at the low STEP bits.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (kill) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start) begin
      a_d    = {{XLEN{1'b0}}, a};
      b_d    = b;
      acc_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      acc_d = step_acc;
      a_d   = a_q << STEP;
      b_d   = b_q >> STEP;
      if (last) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/bitmanip_unit.sv
// Zba/Zbb/Zbs/Zbc execute unit with valid/ready handshakes on both sides.
// Single-cycle ops land in the result register at accept; clmul* iterate in bit_clmul.
module bitmanip_unit
  import bitmanip_unit_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned CLMUL_STEP = 4,
  parameter int unsigned ENABLE_ZBC = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            bit_valid,
  output logic            bit_ready,
  input  logic [4:0]      bit_op,
  input  logic [XLEN-1:0] bit_rs1,
  input  logic [XLEN-1:0] bit_rs2,
  input  logic            bit_kill,
  output logic            bit_rvalid,
  input  logic            bit_rready,
  output logic [XLEN-1:0] bit_result
);

  localparam int unsigned ShW = $clog2(XLEN);

  bit_state_t        state_q, state_d;
  bit_op_t           op_q, op_d, op_in;
  logic [XLEN-1:0]   result_q, result_d;
  logic [XLEN-1:0]   alu_res, clmul_res, orc_res, rev_res, one_hot;
  logic [ShW-1:0]    sh;
  logic [ShW:0]      rsh;
  logic              accept, use_clmul, start, clmul_done;
  logic [2*XLEN-1:0] product;

  assign op_in     = bit_op_t'(bit_op);
  assign sh        = bit_rs2[ShW-1:0];
  assign rsh       = (ShW + 1)'(XLEN) - {1'b0, sh};
  assign one_hot   = {{(XLEN - 1){1'b0}}, 1'b1} << sh;
  assign use_clmul = is_clmul_op(op_in) && (ENABLE_ZBC != 0);

  always_comb begin
    orc_res = '0;
    rev_res = '0;
    for (int k = 0; k < XLEN / 8; k++) begin
      orc_res[8*k +: 8] = (|bit_rs1[8*k +: 8]) ? 8'hFF : 8'h00;
      rev_res[8*k +: 8] = bit_rs1[XLEN - 8 - 8*k +: 8];
    end
  end

  always_comb begin
    alu_res = '0;
    case (op_in)
      OpAndn:   alu_res = bit_rs1 & ~bit_rs2;
      OpOrn:    alu_res = bit_rs1 | ~bit_rs2;
      OpXnor:   alu_res = ~(bit_rs1 ^ bit_rs2);
      OpClz:    alu_res = XLEN'(bit_clz(word_t'(bit_rs1), XLEN));
      OpCtz:    alu_res = XLEN'(bit_ctz(word_t'(bit_rs1), XLEN));
      OpCpop:   alu_res = XLEN'(bit_cpop(word_t'(bit_rs1), XLEN));
      OpMax:    alu_res = ($signed(bit_rs1) >= $signed(bit_rs2)) ? bit_rs1 : bit_rs2;
      OpMaxu:   alu_res = (bit_rs1 >= bit_rs2) ? bit_rs1 : bit_rs2;
      OpMin:    alu_res = ($signed(bit_rs1) <= $signed(bit_rs2)) ? bit_rs1 : bit_rs2;
      OpMinu:   alu_res = (bit_rs1 <= bit_rs2) ? bit_rs1 : bit_rs2;
      OpSextb:  alu_res = {{(XLEN - 8){bit_rs1[7]}}, bit_rs1[7:0]};
      OpSexth:  alu_res = {{(XLEN - 16){bit_rs1[15]}}, bit_rs1[15:0]};
      OpZexth:  alu_res = {{(XLEN - 16){1'b0}}, bit_rs1[15:0]};
      // sh==0 would otherwise need an XLEN-wide complementary shift
      OpRol:    alu_res = (sh == '0) ? bit_rs1 : ((bit_rs1 << sh) | (bit_rs1 >> rsh));
      OpRor:    alu_res = (sh == '0) ? bit_rs1 : ((bit_rs1 >> sh) | (bit_rs1 << rsh));
      OpOrcb:   alu_res = orc_res;
      OpRev8:   alu_res = rev_res;
      OpBset:   alu_res = bit_rs1 | one_hot;
      OpBclr:   alu_res = bit_rs1 & ~one_hot;
      OpBinv:   alu_res = bit_rs1 ^ one_hot;
      OpBext:   alu_res = {{(XLEN - 1){1'b0}}, |(bit_rs1 & one_hot)};
      OpSh1add: alu_res = bit_rs2 + (bit_rs1 << 1);
      OpSh2add: alu_res = bit_rs2 + (bit_rs1 << 2);
      OpSh3add: alu_res = bit_rs2 + (bit_rs1 << 3);
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    case (op_q)
      OpClmulh: clmul_res = product[2*XLEN-1:XLEN];
      OpClmulr: clmul_res = product[2*XLEN-2:XLEN-1];
      default:  clmul_res = product[XLEN-1:0];
    endcase
  end

  bit_clmul #(
    .XLEN(XLEN),
    .STEP(CLMUL_STEP)
  ) u_clmul (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .kill   (bit_kill),
    .a      (bit_rs1),
    .b      (bit_rs2),
    .done   (clmul_done),
    .product(product)
  );

  assign bit_ready  = (state_q == StIdle) || ((state_q == StDone) && bit_rready);
  assign accept     = bit_valid && bit_ready && !bit_kill;
  assign bit_rvalid = (state_q == StDone);
  assign bit_result = result_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    result_d = result_q;
    start    = 1'b0;
    case (state_q)
      StIdle: ;
      StCalc: begin
        if (clmul_done) begin
          state_d  = StDone;
          result_d = clmul_res;
        end
      end
      StDone: begin
        if (bit_rready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Accept in DONE is only possible while the consumer drains, giving back-to-back issue.
    if (accept) begin
      op_d = op_in;
      if (use_clmul) begin
        start   = 1'b1;
        state_d = StCalc;
      end else begin
        state_d  = StDone;
        result_d = alu_res;
      end
    end
    if (bit_kill) begin
      state_d  = StIdle;
      result_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      op_q     <= OpAndn;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_bitmanip_unit.sv
// Directed bench for bitmanip_unit (XLEN=32, CLMUL_STEP=4) with a cycle-level reference
// model checked every cycle, plus hand-computed expectations per vector.
module tb_bitmanip_unit;
  import bitmanip_unit_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned STEP  = 4;
  localparam int          NSTEP = XLEN / STEP;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_ready;
  logic [4:0]  bit_op = 5'd0;
  logic [31:0] bit_rs1 = '0;
  logic [31:0] bit_rs2 = '0;
  logic        bit_kill = 1'b0;
  logic        bit_rvalid;
  logic        bit_rready = 1'b1;
  logic [31:0] bit_result;

  int n_vec = 0;
  int n_err = 0;

  bitmanip_unit #(
    .XLEN      (XLEN),
    .CLMUL_STEP(STEP),
    .ENABLE_ZBC(1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .bit_op    (bit_op),
    .bit_rs1   (bit_rs1),
    .bit_rs2   (bit_rs2),
    .bit_kill  (bit_kill),
    .bit_rvalid(bit_rvalid),
    .bit_rready(bit_rready),
    .bit_result(bit_result)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    int n;
    int sh;
    sh = int'(b[4:0]);
    r = '0;
    p = '0;
    n = 0;
    case (op)
      OpAndn: r = a & ~b;
      OpOrn:  r = a | ~b;
      OpXnor: r = ~(a ^ b);
      OpClz: begin
        for (int i = 31; i >= 0; i--) begin
          if (a[i]) break;
          n++;
        end
        r = 32'(n);
      end
      OpCtz: begin
        for (int i = 0; i < 32; i++) begin
          if (a[i]) break;
          n++;
        end
        r = 32'(n);
      end
      OpCpop: begin
        for (int i = 0; i < 32; i++) if (a[i]) n++;
        r = 32'(n);
      end
      OpMax:  r = ($signed(a) > $signed(b)) ? a : b;
      OpMaxu: r = (a > b) ? a : b;
      OpMin:  r = ($signed(a) < $signed(b)) ? a : b;
      OpMinu: r = (a < b) ? a : b;
      OpSextb: r = {{24{a[7]}}, a[7:0]};
      OpSexth: r = {{16{a[15]}}, a[15:0]};
      OpZexth: r = {16'h0, a[15:0]};
      OpRol: begin
        p = {a, a} << sh;
        r = p[63:32];
      end
      OpRor: begin
        p = {a, a} >> sh;
        r = p[31:0];
      end
      OpOrcb: for (int k = 0; k < 4; k++) r[8*k +: 8] = (a[8*k +: 8] != 8'h0) ? 8'hFF : 8'h00;
      OpRev8: r = {a[7:0], a[15:8], a[23:16], a[31:24]};
      OpBset: r = a | (32'd1 << sh);
      OpBclr: r = a & ~(32'd1 << sh);
      OpBinv: r = a ^ (32'd1 << sh);
      OpBext: r = {31'd0, a[sh]};
      OpSh1add: r = b + a * 2;
      OpSh2add: r = b + a * 4;
      OpSh3add: r = b + a * 8;
      OpClmul, OpClmulh, OpClmulr: begin
        for (int i = 0; i < 32; i++) if (b[i]) p = p ^ ({32'd0, a} << i);
        if (op == OpClmul)       r = p[31:0];
        else if (op == OpClmulh) r = p[63:32];
        else                     r = p[62:31];
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int latency(input logic [4:0] op);
    return (op == OpClmul || op == OpClmulh || op == OpClmulr) ? NSTEP + 1 : 1;
  endfunction

  // Reference model: 0 idle, 1 computing (m_left edges to go), 2 result pending.
  int          m_phase = 0;
  int          m_left = 0;
  logic [31:0] m_res = '0;

  initial forever begin
    @(posedge clock or negedge reset);
    if (!reset) begin
      m_phase = 0;
    end else begin
      if (bit_kill) begin
        m_phase = 0;
      end else if (bit_valid && (m_phase == 0 || (m_phase == 2 && bit_rready))) begin
        m_res = model(bit_op, bit_rs1, bit_rs2);
        if (latency(bit_op) == 1) begin
          m_phase = 2;
        end else begin
          m_phase = 1;
          m_left  = NSTEP;
        end
      end else if (m_phase == 2 && bit_rready) begin
        m_phase = 0;
      end else if (m_phase == 1) begin
        m_left--;
        if (m_left == 0) m_phase = 2;
      end
    end
  end

  initial forever begin
    @(negedge clock);
    check("cmp ready", {31'd0, bit_ready},
          {31'd0, (m_phase == 0) || (m_phase == 2 && bit_rready)});
    check("cmp rvalid", {31'd0, bit_rvalid}, {31'd0, m_phase == 2});
    if (m_phase == 2) check("cmp result", bit_result, m_res);
  end

  task automatic do_op(input string name, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int          lat;
    int          rlow;
    logic        r;
    logic [31:0] res;
    @(negedge clock);
    #1;
    bit_valid  = 1'b1;
    bit_op     = op;
    bit_rs1    = a;
    bit_rs2    = b;
    bit_rready = 1'b1;
    @(negedge clock);
    lat  = 1;
    rlow = bit_ready ? 0 : 1;
    r    = bit_rvalid;
    res  = bit_result;
    #1 bit_valid = 1'b0;
    while (!r && lat < 40) begin
      @(negedge clock);
      lat++;
      if (!bit_ready) rlow++;
      r   = bit_rvalid;
      res = bit_result;
    end
    check({name, " rvalid"}, {31'd0, r}, 32'd1);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " result"}, res, exp);
    check({name, " ready-low cycles"}, 32'(rlow), 32'(exp_lat - 1));
  endtask

  task automatic do_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    do_op($sformatf("op%0d", op), op, a, b, model(op, a, b), latency(op));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int seen;
    repeat (2) @(negedge clock);
    check("reset ready", {31'd0, bit_ready}, 32'd1);
    check("reset rvalid", {31'd0, bit_rvalid}, 32'd0);
    check("reset result", bit_result, 32'd0);
    #1 reset = 1'b1;

    // Pin the model with hand-computed values.
    do_op("clz0", OpClz, 32'h0, 32'h0, 32'd32, 1);
    do_op("ctz0", OpCtz, 32'h0, 32'h0, 32'd32, 1);
    do_op("cpop", OpCpop, 32'hFFFF_FFFF, 32'h0, 32'd32, 1);
    do_op("clz", OpClz, 32'h0001_0000, 32'h0, 32'd15, 1);
    do_op("ctz", OpCtz, 32'h0000_0100, 32'h0, 32'd8, 1);
    do_op("rol1", OpRol, 32'h8000_0000, 32'd1, 32'h0000_0001, 1);
    do_op("ror1", OpRor, 32'h0000_0001, 32'd1, 32'h8000_0000, 1);
    do_op("ror0", OpRor, 32'h1234_5678, 32'd0, 32'h1234_5678, 1);
    do_op("rol36", OpRol, 32'h1234_5678, 32'd36, 32'h2345_6781, 1);
    do_op("min", OpMin, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1);
    do_op("minu", OpMinu, 32'hFFFF_FFFF, 32'd1, 32'h0000_0001, 1);
    do_op("max", OpMax, 32'hFFFF_FFFF, 32'd1, 32'h0000_0001, 1);
    do_op("maxu", OpMaxu, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1);
    do_op("max eq", OpMax, 32'd7, 32'd7, 32'd7, 1);
    do_op("sh3add", OpSh3add, 32'd2, 32'd5, 32'h0000_0015, 1);
    do_op("sh1add wrap", OpSh1add, 32'h8000_0001, 32'd3, 32'h0000_0005, 1);
    do_op("orcb", OpOrcb, 32'h0010_0300, 32'h0, 32'h00FF_FF00, 1);
    do_op("rev8", OpRev8, 32'h1122_3344, 32'h0, 32'h4433_2211, 1);
    do_op("sextb", OpSextb, 32'h0000_0080, 32'h0, 32'hFFFF_FF80, 1);
    do_op("sexth", OpSexth, 32'h0000_8000, 32'h0, 32'hFFFF_8000, 1);
    do_op("zexth", OpZexth, 32'hFFFF_1234, 32'h0, 32'h0000_1234, 1);
    do_op("bset", OpBset, 32'h0, 32'd31, 32'h8000_0000, 1);
    do_op("bclr", OpBclr, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFE, 1);
    do_op("binv", OpBinv, 32'd5, 32'd2, 32'h0000_0001, 1);
    do_op("bext1", OpBext, 32'h10, 32'd4, 32'h0000_0001, 1);
    do_op("bext0", OpBext, 32'h10, 32'd3, 32'h0000_0000, 1);
    do_op("andn", OpAndn, 32'hF0, 32'h30, 32'h0000_00C0, 1);
    do_op("orn", OpOrn, 32'h0, 32'hFFFF_FFFE, 32'h0000_0001, 1);
    do_op("xnor", OpXnor, 32'h0, 32'h0, 32'hFFFF_FFFF, 1);
    do_op("undef", 5'd31, 32'h1234_5678, 32'h9, 32'h0, 1);
    do_op("clmul", OpClmul, 32'd3, 32'd3, 32'h0000_0005, 9);
    do_op("clmulh", OpClmulh, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 9);
    do_op("clmulr", OpClmulr, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 9);

    // Result held while the consumer stalls, then back-to-back accept as it drains.
    @(negedge clock);
    #1;
    bit_valid  = 1'b1;
    bit_op     = OpAndn;
    bit_rs1    = 32'hF0F0_F0F0;
    bit_rs2    = 32'h0FF0_0FF0;
    bit_rready = 1'b0;
    @(negedge clock);
    #1 bit_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("hold rvalid", {31'd0, bit_rvalid}, 32'd1);
      check("hold result", bit_result, 32'hF000_F000);
      check("hold ready", {31'd0, bit_ready}, 32'd0);
    end
    #1;
    bit_rready = 1'b1;
    bit_valid  = 1'b1;
    bit_op     = OpXnor;
    bit_rs1    = 32'h0000_FFFF;
    bit_rs2    = 32'h00FF_00FF;
    #1 check("b2b ready", {31'd0, bit_ready}, 32'd1);
    @(negedge clock);
    check("b2b rvalid", {31'd0, bit_rvalid}, 32'd1);
    check("b2b result", bit_result, 32'hFF00_00FF);
    #1 bit_valid = 1'b0;
    @(negedge clock);
    check("b2b drained", {31'd0, bit_rvalid}, 32'd0);

    // Kill during CALC count 3.
    @(negedge clock);
    #1;
    bit_valid = 1'b1;
    bit_op    = OpClmul;
    bit_rs1   = 32'd5;
    bit_rs2   = 32'd7;
    @(negedge clock);
    #1 bit_valid = 1'b0;
    repeat (3) @(negedge clock);
    #1 bit_kill = 1'b1;
    @(negedge clock);
    check("kill rvalid", {31'd0, bit_rvalid}, 32'd0);
    check("kill ready", {31'd0, bit_ready}, 32'd1);
    #1 bit_kill = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clock);
      if (bit_rvalid) seen++;
    end
    check("kill no late rvalid", 32'(seen), 32'd0);

    // Kill and valid in the same cycle: nothing accepted.
    @(negedge clock);
    #1;
    bit_valid = 1'b1;
    bit_kill  = 1'b1;
    bit_op    = OpCpop;
    bit_rs1   = 32'hFFFF_FFFF;
    @(negedge clock);
    check("kill+valid rvalid", {31'd0, bit_rvalid}, 32'd0);
    #1;
    bit_valid = 1'b0;
    bit_kill  = 1'b0;
    @(negedge clock);
    check("kill+valid later", {31'd0, bit_rvalid}, 32'd0);

    // Reset mid-CALC; leave a non-zero result in place beforehand.
    do_op("rev8 pre-reset", OpRev8, 32'hA1B2_C3D4, 32'h0, 32'hD4C3_B2A1, 1);
    @(negedge clock);
    #1;
    bit_valid = 1'b1;
    bit_op    = OpClmulh;
    bit_rs1   = 32'hDEAD_BEEF;
    bit_rs2   = 32'h1234_5678;
    @(negedge clock);
    #1 bit_valid = 1'b0;
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    #1;
    check("mid reset ready", {31'd0, bit_ready}, 32'd1);
    check("mid reset rvalid", {31'd0, bit_rvalid}, 32'd0);
    check("mid reset result", bit_result, 32'd0);
    @(negedge clock);
    #1 reset = 1'b1;
    do_op("after reset", OpCpop, 32'h0F0F_0001, 32'h0, 32'd9, 1);

    // Sweep every encoding against the reference model.
    for (int op = 0; op < 32; op++) begin
      do_model(5'(op), 32'hA5C3_0F81, 32'h0000_0123);
      do_model(5'(op), 32'h7FFF_0000, 32'hFFFF_FFE1);
    end

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
